// File: rtl/snn_sim_sequencer.sv
// snn_sim_sequencer: run controller between the AXI config registers and the SNN core.
//   On start it resets the network, then runs sim_time timesteps. Each step strobes step_en,
//   waits for step_done, adds out_spikes into saturating per-output counters, then settles.
// Ports:
//   S_AXI_ACLK, Local_Reset (async, active-high)
//   start, clr_counters, sim_time        : control from the config register block
//   step_done, out_spikes                : completion handshake and spike vector from the core
//   step_en, network_reset               : 1-cycle strobes to the core
//   busy, network_done, timestep         : run status back to the config registers
//   spike_counter_out[NUM_OUTPUTS-1:0]   : 32-bit spike totals, one per output neuron
// Latency: start at cycle N -> network_reset at N+1 -> first step_en at N+2. All outputs registered.
// Backpressure: none; the core paces the run through step_done, and step_done outside WAIT is dropped.
module snn_sim_sequencer #(
  parameter int NUM_OUTPUTS   = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   Local_Reset,
  input  logic                   start,
  input  logic                   clr_counters,
  input  logic [31:0]            sim_time,
  input  logic                   step_done,
  input  logic [NUM_OUTPUTS-1:0] out_spikes,
  output logic                   step_en,
  output logic                   network_reset,
  output logic                   busy,
  output logic                   network_done,
  output logic [31:0]            timestep,
  output logic [31:0]            spike_counter_out [NUM_OUTPUTS-1:0]
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // The down-counter is loaded with N-1 so SETTLE occupies exactly N cycles.
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

  logic [2:0]                   r_state;
  logic [31:0]                  r_sim_len;
  logic [31:0]                  r_timestep;
  logic [7:0]                   r_settle_cnt;
  logic                         r_step_en;
  logic                         r_network_reset;
  logic                         r_busy;
  logic                         r_network_done;
  logic [NUM_OUTPUTS-1:0][31:0] r_cnt;

  logic [NUM_OUTPUTS-1:0][31:0] w_cnt_next;
  logic [31:0]                  w_ts_next;
  logic                         w_last_step;

  assign w_ts_next   = r_timestep + 32'd1;
  // sim_len is never 0 here (CLEAR diverts that case), so this terminates before timestep wraps.
  assign w_last_step = (w_ts_next == r_sim_len);

  // Saturating increment per spiking output.
  always_comb begin
    w_cnt_next = r_cnt;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (out_spikes[i] && (r_cnt[i] != 32'hFFFF_FFFF)) begin
        w_cnt_next[i] = r_cnt[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      r_state         <= S_IDLE;
      r_sim_len       <= '0;
      r_timestep      <= '0;
      r_settle_cnt    <= '0;
      r_step_en       <= 1'b0;
      r_network_reset <= 1'b0;
      r_busy          <= 1'b0;
      r_network_done  <= 1'b0;
      r_cnt           <= '0;
    end else begin
      // Strobes default low; they are raised only on entry to CLEAR/STEP.
      r_step_en       <= 1'b0;
      r_network_reset <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sim_len       <= sim_time;
            r_cnt           <= '0;
            r_timestep      <= '0;
            r_network_done  <= 1'b0;
            r_network_reset <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_CLEAR;
          end else if (clr_counters) begin
            r_cnt          <= '0;
            r_timestep     <= '0;
            r_network_done <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (r_sim_len == 32'd0) begin
            r_network_done <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_step_en <= 1'b1;
            r_state   <= S_STEP;
          end
        end
        S_STEP: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (step_done) begin
            r_cnt      <= w_cnt_next;
            r_timestep <= w_ts_next;
            if (w_last_step) begin
              r_network_done <= 1'b1;
              r_state        <= S_DONE;
            end else if (SETTLE_CYCLES == 0) begin
              r_step_en <= 1'b1;
              r_state   <= S_STEP;
            end else begin
              r_settle_cnt <= SETTLE_LOAD;
              r_state      <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            r_step_en <= 1'b1;
            r_state   <= S_STEP;
          end else begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign step_en       = r_step_en;
  assign network_reset = r_network_reset;
  assign busy          = r_busy;
  assign network_done  = r_network_done;
  assign timestep      = r_timestep;

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt_out
    assign spike_counter_out[g] = r_cnt[g];
  end

endmodule

// File: tb/tb_snn_sim_sequencer.sv
// tb_snn_sim_sequencer: directed + randomized bench for snn_sim_sequencer.
//   Acts as the SNN core (answers each step_en with a step_done after a delay) and keeps
//   the expected counters/timestep as plain per-run totals.
// Ports: drives every DUT input; samples outputs on the falling clock edge.
module tb_snn_sim_sequencer;
  localparam int NO = 2;
  localparam int SC = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic          clr        = 1'b0;
  logic [31:0]   sim_time   = '0;
  logic          step_done  = 1'b0;
  logic [NO-1:0] out_spikes = '0;
  logic          step_en;
  logic          network_reset;
  logic          busy;
  logic          network_done;
  logic [31:0]   timestep;
  logic [31:0]   cnt [NO-1:0];

  int n_cmp     = 0;
  int n_bad     = 0;
  int ncyc      = 0;
  int n_se      = 0;
  int n_nr      = 0;
  int last_done = -1;

  logic [31:0] exp_cnt [NO];
  logic [31:0] exp_ts;

  snn_sim_sequencer #(.NUM_OUTPUTS(NO), .SETTLE_CYCLES(SC)) dut (
    .S_AXI_ACLK       (clk),
    .Local_Reset      (rst),
    .start            (start),
    .clr_counters     (clr),
    .sim_time         (sim_time),
    .step_done        (step_done),
    .out_spikes       (out_spikes),
    .step_en          (step_en),
    .network_reset    (network_reset),
    .busy             (busy),
    .network_done     (network_done),
    .timestep         (timestep),
    .spike_counter_out(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Every wait goes through here so strobes are counted on each cycle.
  task automatic tick();
    @(negedge clk);
    ncyc++;
    if (step_en === 1'b1) n_se++;
    if (network_reset === 1'b1) n_nr++;
  endtask

  task automatic model_clear();
    exp_ts = '0;
    for (int i = 0; i < NO; i++) exp_cnt[i] = '0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_ts"}, timestep, exp_ts);
    for (int i = 0; i < NO; i++) chk($sformatf("%s_cnt%0d", tag, i), cnt[i], exp_cnt[i]);
  endtask

  task automatic start_run(input string tag, input logic [31:0] len);
    sim_time = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    sim_time = $urandom;          // later changes must not matter
    model_clear();
    last_done = -1;
    chk1({tag, "_nrst"}, network_reset, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_done_clr"}, network_done, 1'b0);
    tick();
    if (len == 32'd0) chk1({tag, "_done_at2"}, network_done, 1'b1);
    else              chk1({tag, "_first_step"}, step_en, 1'b1);
  endtask

  // Core model: wait for step_en, answer after dly cycles with spk.
  task automatic do_step(input string tag, input int dly, input logic [NO-1:0] spk);
    int t = 0;
    while (step_en !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    chk1({tag, "_step_en"}, step_en, 1'b1);
    if (last_done >= 0) chk({tag, "_gap"}, ncyc - last_done, SC + 1);
    repeat (dly) tick();
    step_done  = 1'b1;
    out_spikes = spk;
    last_done  = ncyc;
    for (int i = 0; i < NO; i++)
      if (spk[i] && exp_cnt[i] != 32'hFFFF_FFFF) exp_cnt[i] = exp_cnt[i] + 1;
    exp_ts = exp_ts + 1;
    tick();
    step_done  = 1'b0;
    out_spikes = '0;
  endtask

  task automatic stray_pulse();
    step_done  = 1'b1;
    out_spikes = '1;
    tick();
    step_done  = 1'b0;
    out_spikes = '0;
  endtask

  task automatic end_run(input string tag);
    chk1({tag, "_done"}, network_done, 1'b1);
    chk1({tag, "_busy_done"}, busy, 1'b1);
    chk_outputs(tag);
    tick();
    chk1({tag, "_idle"}, busy, 1'b0);
    chk1({tag, "_done_sticky"}, network_done, 1'b1);
  endtask

  initial begin
    int se0;
    int nr0;
    int len;
    logic [NO-1:0][31:0] preload;
    logic [NO-1:0] pat [4];

    model_clear();
    repeat (3) tick();
    chk1("rst_step_en", step_en, 1'b0);
    chk1("rst_nrst", network_reset, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", network_done, 1'b0);
    chk_outputs("rst");
    rst = 1'b0;
    tick();

    // T1: three steps, output 0 spikes every step
    se0 = n_se;
    start_run("t1", 3);
    for (int k = 0; k < 3; k++) do_step("t1", 2, 2'b01);
    end_run("t1");
    chk("t1_nstep", n_se - se0, 3);
    chk("t1_cnt0_abs", cnt[0], 3);

    // T2: zero-length run
    se0 = n_se;
    nr0 = n_nr;
    start_run("t2", 0);
    end_run("t2");
    repeat (3) tick();
    chk("t2_nstep", n_se - se0, 0);
    chk("t2_nrst", n_nr - nr0, 1);

    // T3: directed spike pattern
    pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b00;
    start_run("t3", 4);
    for (int k = 0; k < 4; k++) do_step("t3", $urandom_range(1, 3), pat[k]);
    end_run("t3");
    chk("t3_c0_abs", cnt[0], 2);
    chk("t3_c1_abs", cnt[1], 2);

    // T4: start/clr while busy are ignored; clr in IDLE clears
    se0 = n_se;
    start_run("t4", 5);
    for (int k = 0; k < 2; k++) do_step("t4", $urandom_range(1, 3), NO'($urandom));
    start    = 1'b1;
    clr      = 1'b1;
    sim_time = 32'd1;
    tick();
    start = 1'b0;
    clr   = 1'b0;
    for (int k = 0; k < 3; k++) do_step("t4", $urandom_range(1, 3), NO'($urandom));
    end_run("t4");
    chk("t4_nstep", n_se - se0, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    chk_outputs("t4_clr");
    chk1("t4_clr_done", network_done, 1'b0);

    // Randomized runs with stray step_done pulses during SETTLE
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 6);
      se0 = n_se;
      start_run($sformatf("rnd%0d", r), len);
      for (int k = 0; k < len; k++) begin
        do_step($sformatf("rnd%0d", r), $urandom_range(1, 4), NO'($urandom));
        if (k < len - 1 && $urandom_range(0, 1) == 1) stray_pulse();
      end
      end_run($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_nstep", r), n_se - se0, len);
    end

    // T5: reset during WAIT clears at once; later step_done counts nothing
    se0 = n_se;
    start_run("t5", 5);
    do_step("t5", 2, 2'b11);
    for (int t = 0; t < 60 && step_en !== 1'b1; t++) tick();
    chk1("t5_step_en", step_en, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    model_clear();
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_done", network_done, 1'b0);
    chk1("t5_step_en_rst", step_en, 1'b0);
    chk_outputs("t5_async");
    tick();
    rst = 1'b0;
    tick();
    stray_pulse();
    repeat (8) tick();
    chk_outputs("t5_after");
    chk1("t5_busy_after", busy, 1'b0);
    chk("t5_nstep", n_se - se0, 2);

    // T6: stray pulse in IDLE, then saturation from a preloaded counter
    stray_pulse();
    tick();
    chk_outputs("t6_idle");
    start_run("t6", 4);
    do_step("t6", 2, 2'b01);
    preload[0] = 32'hFFFF_FFFE;
    preload[1] = 32'h0000_0010;
    force dut.r_cnt = preload;
    release dut.r_cnt;
    exp_cnt[0] = 32'hFFFF_FFFE;
    exp_cnt[1] = 32'h0000_0010;
    stray_pulse();
    for (int k = 0; k < 3; k++) do_step("t6", $urandom_range(1, 3), 2'b11);
    end_run("t6");
    chk("t6_sat_abs", cnt[0], 32'hFFFF_FFFF);
    chk("t6_c1_abs", cnt[1], 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
